// File: rtl/uart_send_pkg.sv
// uart_send_pkg: shared constants for the UART transmitter.
//   TX_* : transmitter FSM state encodings
//   cw() : counter width helper, never narrower than 1 bit
package uart_send_pkg;

    localparam logic [1:0] TX_IDLE     = 2'd0;
    localparam logic [1:0] TX_STARTBIT = 2'd1;
    localparam logic [1:0] TX_DATABIT  = 2'd2;
    localparam logic [1:0] TX_STOPBIT  = 2'd3;

    // $clog2(1) is 0, which would give a zero-width counter.
    function automatic int cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_send_if.sv
// uart_send_if: host-side toggle handshake of the UART transmitter.
//   data : word to send, stable while req != ack
//   req  : host toggles to request a transmission
//   ack  : follows req once the word is sent or aborted
//   busy : high while a frame is on the line
// Modports: master = host logic, slave = uart_send.
interface uart_send_if #(parameter int DATABITS = 8);
    logic [DATABITS-1:0] data;
    logic                req;
    logic                ack;
    logic                busy;

    modport master (output data, req, input  ack, busy);
    modport slave  (input  data, req, output ack, busy);
endinterface

// File: rtl/uart_send_sync2.sv
// uart_send_sync2: two-flop synchronizer for an asynchronous input.
//   clk, reset_n : clock, async active-low reset
//   i_d          : asynchronous input
//   o_q          : synchronized output
// RST_VAL sets the value both flops take in reset.
module uart_send_sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_d,
    output logic o_q
);
    logic r_meta;
    logic r_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_meta <= RST_VAL;
            r_q    <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;
endmodule

// File: rtl/uart_send.sv
// uart_send: UART transmitter. Takes one word per req/ack toggle handshake
// and sends start bit, DATABITS data bits LSB first, STOPBITS stop bits,
// each bit BAUDDIV clk cycles long. A frame only starts while cts is low.
//   clk, reset_n : clock, async active-low reset
//   soft_reset   : synchronous abort of the frame in flight
//   bus          : handshake (data, req in; ack, busy out)
//   tx           : serial line, idle high
//   cts          : asynchronous peer hold-off, 1 = do not start
module uart_send
    import uart_send_pkg::*;
#(
    parameter int DATABITS = 8,
    parameter int BAUDDIV  = 12,
    parameter int STOPBITS = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       soft_reset,
    uart_send_if.slave bus,
    output logic       tx,
    input  logic       cts
);
    localparam int SW = cw(BAUDDIV);
    localparam int BW = cw(DATABITS);
    localparam int PW = cw(STOPBITS * BAUDDIV);

    localparam logic [SW-1:0] SUB_LAST  = SW'(BAUDDIV - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATABITS - 1);
    localparam logic [PW-1:0] STOP_LAST = PW'(STOPBITS * BAUDDIV - 1);

    logic [1:0]          r_state;
    logic [DATABITS-1:0] r_shift;
    logic [SW-1:0]       r_sub;
    logic [BW-1:0]       r_bit;
    logic [PW-1:0]       r_stop;
    logic                r_ack;
    logic                r_busy;
    logic                r_tx;
    logic                w_cts_s;

    // Resets to 1: nothing goes out until the peer has been seen clear.
    uart_send_sync2 #(.RST_VAL(1'b1)) u_cts_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .i_d     (cts),
        .o_q     (w_cts_s)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= TX_IDLE;
            r_shift <= '0;
            r_sub   <= '0;
            r_bit   <= '0;
            r_stop  <= '0;
            r_ack   <= 1'b0;
            r_busy  <= 1'b0;
            r_tx    <= 1'b1;
        end else if (soft_reset) begin
            // Abort acknowledges the word; in IDLE it also blocks a start.
            if (r_state != TX_IDLE) begin
                r_state <= TX_IDLE;
                r_tx    <= 1'b1;
                r_busy  <= 1'b0;
                r_ack   <= bus.req;
            end
        end else begin
            case (r_state)
                TX_IDLE: begin
                    if ((bus.req != r_ack) && !w_cts_s) begin
                        r_shift <= bus.data;
                        r_tx    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_sub   <= '0;
                        r_bit   <= '0;
                        r_state <= TX_STARTBIT;
                    end
                end
                TX_STARTBIT: begin
                    if (r_sub == SUB_LAST) begin
                        r_sub   <= '0;
                        r_tx    <= r_shift[0];
                        r_shift <= r_shift >> 1;
                        r_state <= TX_DATABIT;
                    end else begin
                        r_sub <= r_sub + 1'b1;
                    end
                end
                TX_DATABIT: begin
                    if (r_sub == SUB_LAST) begin
                        r_sub <= '0;
                        if (r_bit == BIT_LAST) begin
                            r_tx    <= 1'b1;
                            r_stop  <= '0;
                            r_state <= TX_STOPBIT;
                        end else begin
                            r_tx    <= r_shift[0];
                            r_shift <= r_shift >> 1;
                            r_bit   <= r_bit + 1'b1;
                        end
                    end else begin
                        r_sub <= r_sub + 1'b1;
                    end
                end
                TX_STOPBIT: begin
                    if (r_stop == STOP_LAST) begin
                        r_ack   <= bus.req;
                        r_busy  <= 1'b0;
                        r_state <= TX_IDLE;
                    end else begin
                        r_stop <= r_stop + 1'b1;
                    end
                end
                default: r_state <= TX_IDLE;
            endcase
        end
    end

    assign tx       = r_tx;
    assign bus.ack  = r_ack;
    assign bus.busy = r_busy;
endmodule

// File: tb/tb_uart_send.sv
// tb_uart_send: directed bench for uart_send. dut0 uses the default
// parameters, dut1 uses STOPBITS=2, BAUDDIV=4. Inputs change 1 time unit
// after the rising edge; outputs are read at that point too.
module tb_uart_send;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0_n, rst1_n, srst0, srst1, cts0, cts1, tx0, tx1;

    uart_send_if #(.DATABITS(8)) bus0 ();
    uart_send_if #(.DATABITS(8)) bus1 ();

    uart_send #(.DATABITS(8), .BAUDDIV(12), .STOPBITS(1)) dut0 (
        .clk(clk), .reset_n(rst0_n), .soft_reset(srst0),
        .bus(bus0.slave), .tx(tx0), .cts(cts0)
    );
    uart_send #(.DATABITS(8), .BAUDDIV(4), .STOPBITS(2)) dut1 (
        .clk(clk), .reset_n(rst1_n), .soft_reset(srst1),
        .bus(bus1.slave), .tx(tx1), .cts(cts1)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Length of the last run of high cycles on tx0 before a low cycle.
    int hi_run   = 0;
    int last_run = 0;
    always @(negedge clk) begin
        if (tx0 === 1'b1) hi_run <= hi_run + 1;
        else begin
            if (hi_run != 0) last_run <= hi_run;
            hi_run <= 0;
        end
    end

    task automatic wait_ack0(input string tag);
        int n;
        n = 0;
        while (bus0.ack !== bus0.req && n < 300) begin
            tick;
            n++;
        end
        chk(tag, bus0.ack, bus0.req);
    endtask

    // Sends one word on dut0 (cts_s must already be low) and checks every
    // line cycle against frame {stop, data, start}. cts0 rises at cycle
    // cts_at of the frame (-1: never). Returns in the cycle ack toggles.
    task automatic frame0(input logic [7:0] w, input string tag, input int cts_at);
        logic [9:0] exp_f;
        int bad, bcnt;
        exp_f = {1'b1, w, 1'b0};
        bus0.data = w;
        bus0.req  = ~bus0.req;
        tick;
        bad  = 0;
        bcnt = 0;
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < 12; c++) begin
                if (b * 12 + c == cts_at) cts0 = 1'b1;
                if (tx0 !== exp_f[b]) bad++;
                if (bus0.busy === 1'b1) bcnt++;
                tick;
            end
        end
        chk({tag, "_bits"}, bad, 0);
        chk({tag, "_busy_len"}, bcnt, 120);
        chk({tag, "_ack"}, bus0.ack, bus0.req);
        chk({tag, "_busy_end"}, bus0.busy, 1'b0);
    endtask

    initial begin
        int bad, n, run;
        logic [10:0] f;

        rst0_n = 1'b0; rst1_n = 1'b0; srst0 = 1'b0; srst1 = 1'b0;
        cts0 = 1'b1; cts1 = 1'b0;
        bus0.data = '0; bus0.req = 1'b0;
        bus1.data = '0; bus1.req = 1'b0;
        repeat (3) tick;
        chk("rst_tx0", tx0, 1'b1);
        chk("rst_ack0", bus0.ack, 1'b0);
        chk("rst_busy0", bus0.busy, 1'b0);
        chk("rst_tx1", tx1, 1'b1);
        rst0_n = 1'b1; rst1_n = 1'b1;
        repeat (3) tick;

        // cts held high: request must wait, then start 3 edges after cts falls.
        bus0.data = 8'hA5;
        bus0.req  = ~bus0.req;
        bad = 0;
        repeat (50) begin
            tick;
            if (tx0 !== 1'b1 || bus0.busy !== 1'b0) bad++;
        end
        chk("cts_hold", bad, 0);
        cts0 = 1'b0;
        n = 0;
        while (tx0 !== 1'b0 && n < 10) begin
            tick;
            n++;
        end
        chk("cts_latency_ok", (n >= 2 && n <= 3), 1'b1);
        wait_ack0("cts_ack");
        repeat (3) tick;

        // Plain frame, then back-to-back 0x00 / 0xFF.
        frame0(8'hA5, "a5", -1);
        repeat (5) tick;
        frame0(8'h00, "w00", -1);
        frame0(8'hFF, "wff", -1);
        chk("b2b_gap", last_run, 13);
        repeat (3) tick;

        // cts rises during data bit 3: frame unaffected, next one held.
        frame0(8'h96, "cts_mid", 4 * 12 + 5);
        bus0.data = 8'h33;
        bus0.req  = ~bus0.req;
        bad = 0;
        repeat (20) begin
            tick;
            if (tx0 !== 1'b1 || bus0.busy !== 1'b0) bad++;
        end
        chk("cts_mid_hold", bad, 0);
        cts0 = 1'b0;
        wait_ack0("cts_mid_next_ack");
        repeat (3) tick;

        // soft_reset in data bit 5 of 0xC3 (that bit is 0 on the line).
        bus0.data = 8'hC3;
        bus0.req  = ~bus0.req;
        tick;
        repeat (6 * 12 + 4) tick;
        chk("sr_pre_tx", tx0, 1'b0);
        srst0 = 1'b1;
        tick;
        srst0 = 1'b0;
        chk("sr_tx", tx0, 1'b1);
        chk("sr_ack", bus0.ack, bus0.req);
        chk("sr_busy", bus0.busy, 1'b0);
        bad = 0;
        repeat (30) begin
            tick;
            if (tx0 !== 1'b1) bad++;
        end
        chk("sr_quiet", bad, 0);

        // soft_reset in IDLE with a request pending: start slips one cycle.
        bus0.data = 8'hA5;
        bus0.req  = ~bus0.req;
        srst0 = 1'b1;
        tick;
        srst0 = 1'b0;
        chk("sr_idle_nostart", tx0, 1'b1);
        tick;
        chk("sr_idle_start", tx0, 1'b0);
        wait_ack0("sr_idle_ack");

        // dut1: 2 stop bits, 4 cycles per bit, 0x3C.
        bus1.data = 8'h3C;
        bus1.req  = ~bus1.req;
        tick;
        n = 0; run = 0; f = '0;
        while (bus1.ack !== bus1.req && n < 100) begin
            if (n % 4 == 2 && n / 4 < 11) f[n / 4] = tx1;
            if (tx1 === 1'b1) run++;
            else run = 0;
            tick;
            n++;
        end
        chk("d1_frame_len", n, 44);
        chk("d1_stop_len", run, 8);
        chk("d1_bits", f, 11'b11_00111100_0);

        // Async reset mid-frame (data bit 1 of 0x55 is low on the line).
        bus1.data = 8'h55;
        bus1.req  = ~bus1.req;
        repeat (10) tick;
        chk("d1_pre_busy", bus1.busy, 1'b1);
        #2;
        rst1_n = 1'b0;
        #1;
        chk("d1_rst_tx", tx1, 1'b1);
        chk("d1_rst_ack", bus1.ack, 1'b0);
        chk("d1_rst_busy", bus1.busy, 1'b0);
        tick;
        rst1_n = 1'b1;
        tick;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout act=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
